// File: rtl/rx_serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial receiver: FSM state encodings
// (also exported on db_estado) and the frame constants.
package rx_serial_7e1_pkg;

  typedef enum logic [3:0] {
    REPOUSO      = 4'd0,
    START        = 4'd1,
    DADOS        = 4'd2,
    STOP         = 4'd3,
    ARMAZENA     = 4'd4,
    ESPERA_LINHA = 4'd5
  } estado_t;

  localparam int unsigned N_DADOS       = 7;     // ASCII data bits
  localparam int unsigned N_PAYLOAD     = 8;     // data bits + parity bit
  localparam logic        NIVEL_STOP    = 1'b1;
  localparam logic        NIVEL_REPOUSO = 1'b1;

  // 1 when the payload holds an even number of ones.
  function automatic logic paridade_par(input logic [N_PAYLOAD-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up-counter with synchronous clear and count enable.
// Ports: clock, reset (async, active high), zera (sync clear, has priority),
//        conta (count enable), q (current value, wraps to 0 after M-1).
module contador_m #(
  parameter int unsigned M = 16,
  parameter int unsigned N = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_serial_7e1_fd.sv
// Datapath of the 7E1 receiver: 2-FF line synchroniser, tick and bit
// counters, payload shift register, stop sample and output registers.
// Control inputs come from the FSM in rx_serial_7e1.
// Ports:
//   clock, reset                     clock, async active-high reset
//   dado_serial                      raw serial line
//   zera_tick, conta_tick            tick counter clear / enable
//   zera_bits                        bit counter clear
//   desloca                          shift one payload bit (also counts it)
//   amostra_stop                     capture the stop bit
//   carrega_saidas                   load output registers, pulse pronto
//   seta_ocupado                     raise ocupado
//   linha                            synchronised line to the FSM
//   tick_meio, tick_fim              tick counter at M/2, at M-1
//   ultimo_bit                       next shift is the last payload bit
//   stop_ok                          captured stop bit had the stop level
//   dados_ascii..ocupado             registered receiver outputs
module rx_serial_7e1_fd
  import rx_serial_7e1_pkg::*;
#(
  parameter int unsigned M = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 zera_tick,
  input  logic                 conta_tick,
  input  logic                 zera_bits,
  input  logic                 desloca,
  input  logic                 amostra_stop,
  input  logic                 carrega_saidas,
  input  logic                 seta_ocupado,
  output logic                 linha,
  output logic                 tick_meio,
  output logic                 tick_fim,
  output logic                 ultimo_bit,
  output logic                 stop_ok,
  output logic [N_DADOS-1:0]   dados_ascii,
  output logic                 pronto,
  output logic                 paridade_ok,
  output logic                 erro_stop,
  output logic                 ocupado
);

  localparam int unsigned TW = $clog2(M);

  logic                 sinc1, sinc2;
  logic [TW-1:0]        tick_q;
  logic [3:0]           bit_q;
  logic [N_PAYLOAD-1:0] desloc;
  logic                 stop_amostra;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1 <= NIVEL_REPOUSO;
      sinc2 <= NIVEL_REPOUSO;
    end else begin
      sinc1 <= dado_serial;
      sinc2 <= sinc1;
    end
  end

  assign linha = sinc2;

  contador_m #(.M(M)) u_tick (
    .clock (clock),
    .reset (reset),
    .zera  (zera_tick),
    .conta (conta_tick),
    .q     (tick_q)
  );

  contador_m #(.M(16)) u_bits (
    .clock (clock),
    .reset (reset),
    .zera  (zera_bits),
    .conta (desloca),
    .q     (bit_q)
  );

  assign tick_meio  = (tick_q == TW'(M / 2));
  assign tick_fim   = (tick_q == TW'(M - 1));
  assign ultimo_bit = (bit_q == 4'(N_PAYLOAD - 1));
  assign stop_ok    = (stop_amostra == NIVEL_STOP);

  // LSB arrives first, so shifting in at the top leaves bit 0 in desloc[0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      desloc       <= '0;
      stop_amostra <= NIVEL_STOP;
    end else begin
      if (desloca)      desloc       <= {linha, desloc[N_PAYLOAD-1:1]};
      if (amostra_stop) stop_amostra <= linha;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados_ascii <= '0;
      pronto      <= 1'b0;
      paridade_ok <= 1'b0;
      erro_stop   <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      pronto <= carrega_saidas;
      if (carrega_saidas) begin
        dados_ascii <= desloc[N_DADOS-1:0];
        paridade_ok <= paridade_par(desloc);
        erro_stop   <= (stop_amostra != NIVEL_STOP);
        ocupado     <= 1'b0;
      end else if (seta_ocupado) begin
        ocupado <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver (1 start, 7 data LSB first, even parity,
// 1 stop). Recovers the character, checks parity and framing and signals
// completion with a one-cycle pronto pulse.
// Ports:
//   clock, reset   system clock, async active-high reset
//   dado_serial    serial line, idle high
//   dados_ascii    last received character (held)
//   pronto         one-cycle pulse, outputs valid in that cycle
//   paridade_ok    payload had even parity (held)
//   erro_stop      stop bit sampled low (held)
//   ocupado        high from start confirmation until pronto
//   db_estado      FSM state encoding
module rx_serial_7e1
  import rx_serial_7e1_pkg::*;
#(
  parameter int unsigned M = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       paridade_ok,
  output logic       erro_stop,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  estado_t estado;

  logic linha, tick_meio, tick_fim, ultimo_bit, stop_ok;
  logic zera_tick, conta_tick, zera_bits, desloca, amostra_stop;
  logic carrega_saidas, seta_ocupado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= REPOUSO;
    end else begin
      case (estado)
        REPOUSO:      if (linha != NIVEL_REPOUSO) estado <= START;
        START:        if (tick_meio) estado <= (linha == NIVEL_REPOUSO) ? REPOUSO : DADOS;
        DADOS:        if (tick_fim && ultimo_bit) estado <= STOP;
        STOP:         if (tick_fim) estado <= ARMAZENA;
        ARMAZENA:     estado <= stop_ok ? REPOUSO : ESPERA_LINHA;
        ESPERA_LINHA: if (linha == NIVEL_REPOUSO) estado <= REPOUSO;
        default:      estado <= REPOUSO;
      endcase
    end
  end

  // Counters are held clear for the whole idle period rather than only on
  // the detecting edge; the value seen on entry to START is identical.
  always_comb begin
    zera_tick      = 1'b0;
    conta_tick     = 1'b0;
    zera_bits      = 1'b0;
    desloca        = 1'b0;
    amostra_stop   = 1'b0;
    carrega_saidas = 1'b0;
    seta_ocupado   = 1'b0;
    case (estado)
      REPOUSO: begin
        zera_tick = 1'b1;
        zera_bits = 1'b1;
      end
      START: begin
        conta_tick = 1'b1;
        if (tick_meio && (linha != NIVEL_REPOUSO)) begin
          zera_tick    = 1'b1;
          seta_ocupado = 1'b1;
        end
      end
      DADOS: begin
        conta_tick = 1'b1;
        desloca    = tick_fim;
      end
      STOP: begin
        conta_tick   = 1'b1;
        amostra_stop = tick_fim;
      end
      ARMAZENA: carrega_saidas = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

  rx_serial_7e1_fd #(.M(M)) u_fd (
    .clock          (clock),
    .reset          (reset),
    .dado_serial    (dado_serial),
    .zera_tick      (zera_tick),
    .conta_tick     (conta_tick),
    .zera_bits      (zera_bits),
    .desloca        (desloca),
    .amostra_stop   (amostra_stop),
    .carrega_saidas (carrega_saidas),
    .seta_ocupado   (seta_ocupado),
    .linha          (linha),
    .tick_meio      (tick_meio),
    .tick_fim       (tick_fim),
    .ultimo_bit     (ultimo_bit),
    .stop_ok        (stop_ok),
    .dados_ascii    (dados_ascii),
    .pronto         (pronto),
    .paridade_ok    (paridade_ok),
    .erro_stop      (erro_stop),
    .ocupado        (ocupado)
  );

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Bench for rx_serial_7e1 with M=8: directed frames from a bit-accurate
// serialiser plus random frames, checked against expected records built
// from the frame rules (character, parity count, stop level, latency).
module tb_rx_serial_7e1;
  import rx_serial_7e1_pkg::*;

  localparam int unsigned M = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dado_serial = 1'b1;
  logic [6:0] dados_ascii;
  logic       pronto, paridade_ok, erro_stop, ocupado;
  logic [3:0] db_estado;

  rx_serial_7e1 #(.M(M)) dut (
    .clock       (clock),
    .reset       (reset),
    .dado_serial (dado_serial),
    .dados_ascii (dados_ascii),
    .pronto      (pronto),
    .paridade_ok (paridade_ok),
    .erro_stop   (erro_stop),
    .ocupado     (ocupado),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] d;
    logic       p;
    logic       e;
    logic       o;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   n_ocup = 0;

  always @(negedge clock) begin
    rec_t r;
    if (pronto === 1'b1) begin
      r.cyc = cyc; r.d = dados_ascii; r.p = paridade_ok; r.e = erro_stop; r.o = ocupado;
      obs_q.push_back(r);
    end
    if (ocupado === 1'b1) n_ocup++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " dados_ascii"}, 32'(dados_ascii), 32'h0);
    chk({tag, " pronto"},      32'(pronto),      32'h0);
    chk({tag, " paridade_ok"}, 32'(paridade_ok), 32'h0);
    chk({tag, " erro_stop"},   32'(erro_stop),   32'h0);
    chk({tag, " ocupado"},     32'(ocupado),     32'h0);
    chk({tag, " db_estado"},   32'(db_estado),   32'(REPOUSO));
  endtask

  task automatic drive_bit(input logic b);
    dado_serial = b;
    repeat (M) @(negedge clock);
  endtask

  // Called on a negedge. Builds the expected record, then serialises.
  task automatic send_frame(input logic [6:0] ch, input logic par_err,
                            input logic stop_v, input int brk);
    logic [9:0]  bits;
    logic [6:0]  tmp;
    int          ones;
    logic        par;
    rec_t        e;
    tmp  = ch;
    ones = 0;
    for (int i = 0; i < 7; i++) if (tmp[i]) ones++;
    par  = ((ones % 2) == 1) ^ par_err;
    if (par) ones++;
    bits  = {stop_v, par, ch, 1'b0};
    e.cyc = cyc + 1 + 9 * M + M / 2 + 4;
    e.d   = ch;
    e.p   = ((ones % 2) == 0);
    e.e   = (stop_v == 1'b0);
    e.o   = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      dado_serial = bits[i];
      repeat (M / 2) @(negedge clock);
      if (i == 5) begin
        chk("mid-frame ocupado", 32'(ocupado), 32'h1);
        chk("mid-frame state",   32'(db_estado), 32'(DADOS));
      end
      repeat (M - M / 2) @(negedge clock);
    end
    repeat (brk) drive_bit(1'b0);
    if (!stop_v) drive_bit(1'b1);
  endtask

  task automatic check_results(input string tag);
    rec_t o, x;
    for (int i = 0; i < 400 && obs_q.size() < exp_q.size(); i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk({tag, " pronto count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, " latency"},     32'(o.cyc), 32'(x.cyc));
      chk({tag, " dados_ascii"}, 32'(o.d),   32'(x.d));
      chk({tag, " paridade_ok"}, 32'(o.p),   32'(x.p));
      chk({tag, " erro_stop"},   32'(o.e),   32'(x.e));
      chk({tag, " ocupado@pronto"}, 32'(o.o), 32'(x.o));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    logic [6:0] ch;
    logic pe, sv;
    int gap;

    reset = 1'b1;
    dado_serial = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_outs("reset");
    reset = 1'b0;
    repeat (2 * M) @(negedge clock);

    send_frame(7'h41, 1'b0, 1'b1, 0);
    check_results("0x41");

    reset = 1'b1;
    @(negedge clock);
    chk_reset_outs("re-reset");
    reset = 1'b0;
    repeat (M) @(negedge clock);

    send_frame(7'h43, 1'b1, 1'b1, 0);
    check_results("0x43 bad parity");

    o0 = n_ocup;
    dado_serial = 1'b0;
    @(negedge clock);
    dado_serial = 1'b1;
    repeat (200) @(negedge clock);
    chk("glitch pronto count", 32'(obs_q.size()), 32'h0);
    chk("glitch ocupado cycles", 32'(n_ocup - o0), 32'h0);

    send_frame(7'h2A, 1'b0, 1'b0, 30);
    send_frame(7'h55, 1'b0, 1'b1, 0);
    check_results("break");

    dado_serial = 1'b0;
    repeat (M) @(negedge clock);
    repeat (4) drive_bit(1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outs("abort");
    reset = 1'b0;
    dado_serial = 1'b1;
    repeat (2 * M) @(negedge clock);
    send_frame(7'h30, 1'b0, 1'b1, 0);
    send_frame(7'h31, 1'b0, 1'b1, 0);
    check_results("abort+b2b");

    for (int k = 0; k < 10; k++) begin
      ch  = 7'($urandom_range(0, 127));
      pe  = ($urandom_range(0, 3) == 0);
      sv  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      send_frame(ch, pe, sv, 0);
      repeat (gap) drive_bit(1'b1);
    end
    check_results("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7e1

Serial receiver for 7E1 asynchronous frames: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit. It sits directly downstream of the team's 7E1 serial transmitter, sharing its line convention: idle high, start low, even parity over the 7 data bits. It recovers the ASCII character and checks parity and framing. It hands the result to the consumer with a one-cycle `pronto` pulse.

## Interface
- `M`, default 434: clock cycles per bit (50 MHz / 115200 baud); legal range M ≥ 4.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dado_serial`  in  1  asynchronous serial line; idle = 1.
- `dados_ascii`  out  7  last received character; held until the next frame completes.
- `pronto`  out  1  one-cycle pulse; the other outputs are valid in that cycle.
- `paridade_ok`  out  1  1 when data bits plus parity bit contain an even number of 1s; held.
- `erro_stop`  out  1  1 when the stop bit was sampled as 0; held.
- `ocupado`  out  1  1 from start confirmation until `pronto`.
- `db_estado`  out  4  current FSM state encoding, for debug.

## Operation
- Synchroniser: `dado_serial` passes through 2 flip-flops, each reset to 1. The FSM sees only the synchronised line.
- FSM states:
  - REPOUSO: wait for line = 0. Then zero the tick counter and the bit counter, and go to START.
  - START: when the tick counter reaches ⌊M/2⌋, check the line.
    - Line 0: zero the tick counter, set `ocupado`, go to DADOS.
    - Line 1: false start; go to REPOUSO, no outputs change.
  - DADOS: each time the tick counter reaches M−1, shift the line into an 8-bit shift register (LSB first) and increment the bit counter. After the 8th sample (7 data + parity), go to STOP.
  - STOP: when the tick counter reaches M−1, sample the stop bit, then go to ARMAZENA.
  - ARMAZENA: one cycle. Load `dados_ascii` with shift bits [6:0] and `paridade_ok` with ~^shift[7:0]. Load `erro_stop` with the inverted stop sample. Pulse `pronto`, clear `ocupado`.
    - Next state is REPOUSO if the stop sample was 1.
    - Next state is ESPERA_LINHA if the stop sample was 0.
  - ESPERA_LINHA: wait for line = 1, then go to REPOUSO. A line held low (break) therefore produces exactly one frame.
- Parity errors and stop errors never suppress `pronto`; the consumer decides what to do with them.
- Tick counter is ⌈log2 M⌉ bits wide and wraps to 0 at M−1. Bit counter is 4 bits wide.

## Timing
- Reset values: `dados_ascii`=0, `pronto`=0, `paridade_ok`=0, `erro_stop`=0, `ocupado`=0, state REPOUSO, synchroniser=1.
- Reset asserted mid-frame: abort immediately, all outputs return to their reset values, no `pronto`.
- Sample points: mid-bit, ⌊M/2⌋ + k·M cycles after start detection, for k = 1..9.
- Latency: `pronto` is high in cycle 9·M + ⌊M/2⌋ + 4, counted from the rising edge at which `dado_serial` is first sampled low.
- Back-to-back frames: a new start bit arriving right after the stop bit is accepted. The FSM is back in REPOUSO about M/2 cycles before the stop bit ends.
- A low glitch shorter than ⌊M/2⌋ − 2 cycles is rejected as a false start.

## Structure
- Shared package/header holds:
  - the state encodings, also used for `db_estado`;
  - the frame constants: 7 data bits, 8 sampled payload bits, stop level 1, idle level 1.
- Natural split: `rx_serial_7e1_fd` datapath, containing the synchroniser, tick and bit counters (reusing `contador_m`), shift register and output registers. It is controlled by the FSM in the top level `rx_serial_7e1`.

## Test plan
Run with M=8. Frames are driven bit-accurately by a bench serialiser (or by the 7E1 transmitter itself).
1. Reset: hold `reset` with the line high → all outputs 0 and `db_estado` = REPOUSO; outputs return to 0 when reset is re-asserted.
2. 0x41, parity bit 0 → exactly one `pronto` in cycle 9·8+4+4=80; `dados_ascii`=0x41, `paridade_ok`=1, `erro_stop`=0.
3. 0x43 sent with a wrong parity bit 0 → `dados_ascii`=0x43, `paridade_ok`=0, `pronto` still pulses.
4. Line low for 1 cycle, then idle for 200 cycles → no `pronto`, `ocupado` never 1.
5. 0x2A with stop bit 0, then the line held low for 30 bit times, then high, then 0x55 → first `pronto` has `erro_stop`=1. No extra `pronto` during the break. Second `pronto` has `dados_ascii`=0x55, `erro_stop`=0, `paridade_ok`=1.
6. `reset` pulsed after the 4th data bit of 0x7F, then back-to-back frames 0x30 and 0x31 → no `pronto` for the aborted frame. Two pulses follow, carrying 0x30 and 0x31, both with `paridade_ok`=1.
